// File: rtl/bcd_conv_pkg.sv
// ============================================================================
// Module   : bcd_conv_pkg
// Brief    : Shared types for the BCD converter arbiter (FSM states, digit).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_conv_pkg;

  // Job sequencing states of the arbiter
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // One packed BCD digit
  typedef logic [3:0] digit_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker. Searches req starting one
//            above ptr (wrapping) and returns a one-hot grant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       any_req
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic w_found;

  // First set request after ptr, wrapping, wins the grant
  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!w_found && req[PTR_W'((int'(ptr) + i) % NUM_REQ)]) begin
        grant[PTR_W'((int'(ptr) + i) % NUM_REQ)] = 1'b1;
        w_found = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

`default_nettype wire

// File: rtl/bcd_conv_arbiter.sv
// ============================================================================
// Module   : bcd_conv_arbiter
// Brief    : Shares one binary->BCD converter between NUM_REQ requesters.
//            Round-robin grant, drives the converter load pulse, waits for a
//            rising enaOut (or times out) and routes the result back.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_conv_arbiter
  import bcd_conv_pkg::*;
#(
  parameter int binaryNumberWidth = 32,
  parameter int numberOfDigits    = 6,
  parameter int NUM_REQ           = 4,
  parameter int LOAD_CYCLES       = 2,
  parameter int TIMEOUT_CYCLES    = 4096
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_REQ-1:0]                            reqValid,
  input  logic [NUM_REQ-1:0][binaryNumberWidth-1:0]     reqNumber,
  output logic [NUM_REQ-1:0]                            reqReady,
  output logic [NUM_REQ-1:0]                            rspValid,
  output logic [numberOfDigits-1:0][3:0]                rspDigits,
  output logic                                          rspError,
  output logic [binaryNumberWidth-1:0]                  convBinaryNumber,
  output logic                                          convLoad,
  input  logic [numberOfDigits-1:0][3:0]                convBinaryDecimal,
  input  logic                                          convEnaOut
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int LC_W  = $clog2(LOAD_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [LC_W-1:0]  c_load_last = LC_W'(LOAD_CYCLES - 1);
  localparam logic [TO_W-1:0]  c_to_last   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W-1:0] c_ptr_init  = PTR_W'(NUM_REQ - 1);

  state_t                          r_state;
  logic [PTR_W-1:0]                r_ptr;
  logic [NUM_REQ-1:0]              r_grant;
  logic [LC_W-1:0]                 r_load_cnt;
  logic [TO_W-1:0]                 r_to_cnt;
  logic                            r_ena_prev;
  logic [binaryNumberWidth-1:0]    r_conv_num;
  logic                            r_conv_load;
  logic [NUM_REQ-1:0]              r_rsp_valid;
  digit_t [numberOfDigits-1:0]     r_digits;
  logic                            r_error;

  logic [NUM_REQ-1:0]              w_grant;
  logic                            w_any_req;
  logic [PTR_W-1:0]                w_grant_idx;
  logic                            w_ena_rise;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req     (reqValid),
    .ptr     (r_ptr),
    .grant   (w_grant),
    .any_req (w_any_req)
  );

  // Encode the one-hot grant into an index for operand select and pointer
  always_comb begin
    w_grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_grant_idx = PTR_W'(i);
    end
  end

  // A level that was already high is stale; only a fresh 0->1 completes a job
  assign w_ena_rise = convEnaOut & ~r_ena_prev;

  // Grants are only offered while idle
  assign reqReady = (r_state == IDLE) ? w_grant : '0;

  // Job sequencer: grant capture, load pulse, completion/timeout, response
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= c_ptr_init;
      r_grant     <= '0;
      r_load_cnt  <= '0;
      r_to_cnt    <= '0;
      r_ena_prev  <= 1'b1;
      r_conv_num  <= '0;
      r_conv_load <= 1'b0;
      r_rsp_valid <= '0;
      r_digits    <= '0;
      r_error     <= 1'b0;
    end else begin
      r_ena_prev  <= convEnaOut;
      r_rsp_valid <= '0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_conv_num  <= reqNumber[w_grant_idx];
            r_grant     <= w_grant;
            r_ptr       <= w_grant_idx;
            r_conv_load <= 1'b1;
            r_load_cnt  <= '0;
            r_state     <= LOAD;
          end
        end
        LOAD: begin
          if (r_load_cnt == c_load_last) begin
            r_conv_load <= 1'b0;
            r_to_cnt    <= '0;
            r_state     <= WAIT;
          end else begin
            r_load_cnt <= r_load_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (w_ena_rise) begin
            r_digits    <= convBinaryDecimal;
            r_error     <= 1'b0;
            r_rsp_valid <= r_grant;
            r_state     <= DONE;
          end else if (r_to_cnt == c_to_last) begin
            r_digits    <= '0;
            r_error     <= 1'b1;
            r_rsp_valid <= r_grant;
            r_state     <= DONE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rspValid         = r_rsp_valid;
  assign rspDigits        = r_digits;
  assign rspError         = r_error;
  assign convBinaryNumber = r_conv_num;
  assign convLoad         = r_conv_load;

endmodule

`default_nettype wire
